// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- register file with an integrated per-register busy scoreboard.
//
// One instance holds the integer file (ZERO_REG = 1, NRD = 2), another the FP
// file (ZERO_REG = 0, NRD = 3). Decode reads operands and busy bits through
// the combinational read ports and stalls on RAW (rd_busy) and WAW (iss_busy)
// hazards. Busy is set when an instruction with a destination issues and
// cleared when its result comes back on either write port.
//
// Optional feature macro: REGFILE_SB_BYPASS_EN
//   defined   : a read that hits a write active this cycle returns the write
//               data (WP0 over WP1) and reports not-busy, unless an issue to
//               the same register happens in the same cycle.
//   undefined : reads return stored contents; writes show up a cycle later.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous active-high reset (clears data and busy)
//   rd_addr    in   NRD*AW    read addresses, port i at [i*AW +: AW]
//   rd_data    out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//   rd_busy    out  NRD       busy bit of each port's addressed register
//   wr0_*      in   write port 0 (ALU/FPU writeback): en, addr, data
//   wr1_*      in   write port 1 (load writeback): en, addr, data
//   iss_en     in   an instruction with a destination issues this cycle
//   iss_addr   in   destination register of the issuing instruction
//   iss_busy   out  busy bit of iss_addr, from current state only
//   busy_any   out  OR of all busy bits, from current state only
//
// Handshake note: there is no valid/ready flow control here. Every enable
// (wr0_en, wr1_en, iss_en) is a single-cycle strobe that is always accepted
// on the rising edge it is high for; the block never back-pressures. The
// decoder is responsible for not issuing into a busy register.
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_busy,
  output logic                busy_any
);

  localparam bit            HW_ZERO   = (ZERO_REG != 0);
  localparam logic [AW-1:0] ZERO_ADDR = '0;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Qualified write/issue strobes. Register 0 is untouchable when it is
  // hardwired. On a same-address collision WP1 is dropped so WP0's data wins.
  logic wr0_ok;
  logic wr1_ok;
  logic iss_ok;

  assign wr0_ok = wr0_en && !(HW_ZERO && (wr0_addr == ZERO_ADDR));
  assign wr1_ok = wr1_en && !(HW_ZERO && (wr1_addr == ZERO_ADDR))
                  && !(wr0_en && (wr0_addr == wr1_addr));
  assign iss_ok = iss_en && !(HW_ZERO && (iss_addr == ZERO_ADDR));

  // -------------------------------------------------------------------------
  // Data storage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // Clears are applied first and the issue set last, so an issue and a
  // writeback to the same register in one cycle leaves it pending: the new
  // producer is still outstanding even though the old result was stored.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_nxt = busy;
    if (wr0_en) busy_nxt[wr0_addr] = 1'b0;
    if (wr1_en) busy_nxt[wr1_addr] = 1'b0;
    if (iss_ok) busy_nxt[iss_addr] = 1'b1;
    if (HW_ZERO) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign iss_busy = busy[iss_addr];
  assign busy_any = |busy;

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;
    rd_data = '0;
    rd_busy = '0;
    a       = '0;
    d       = '0;
    b       = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      a = rd_addr[i*AW +: AW];
      d = regs[a];
      b = busy[a];
`ifdef REGFILE_SB_BYPASS_EN
      // Forwarding is suppressed during reset so outputs read as zero, and
      // never applies to a hardwired register 0.
      if (!rst && !(HW_ZERO && (a == ZERO_ADDR))) begin
        if (wr0_en && (wr0_addr == a)) begin
          d = wr0_data;
          b = iss_en && (iss_addr == a);
        end else if (wr1_en && (wr1_addr == a)) begin
          d = wr1_data;
          b = iss_en && (iss_addr == a);
        end
      end
`endif
      if (HW_ZERO && (a == ZERO_ADDR)) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[i*XLEN +: XLEN] = d;
      rd_busy[i]              = b;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb -- directed bench for regfile_sb. Two instances: the integer
// configuration (defaults) and the FP configuration (ZERO_REG = 0, NRD = 3).
// Expectations depending on the forwarding option follow the same macro.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD_I = 2;
  localparam int NRD_F = 3;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // integer instance signals
  logic [NRD_I*AW-1:0]   i_rd_addr;
  logic [NRD_I*XLEN-1:0] i_rd_data;
  logic [NRD_I-1:0]      i_rd_busy;
  logic                  i_wr0_en, i_wr1_en, i_iss_en;
  logic [AW-1:0]         i_wr0_addr, i_wr1_addr, i_iss_addr;
  logic [XLEN-1:0]       i_wr0_data, i_wr1_data;
  logic                  i_iss_busy, i_busy_any;

  // FP instance signals
  logic [NRD_F*AW-1:0]   f_rd_addr;
  logic [NRD_F*XLEN-1:0] f_rd_data;
  logic [NRD_F-1:0]      f_rd_busy;
  logic                  f_wr0_en, f_wr1_en, f_iss_en;
  logic [AW-1:0]         f_wr0_addr, f_wr1_addr, f_iss_addr;
  logic [XLEN-1:0]       f_wr0_data, f_wr1_data;
  logic                  f_iss_busy, f_busy_any;

  int n_vec = 0;
  int n_bad = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD_I), .ZERO_REG(1)) u_int (
    .clk(clk), .rst(rst),
    .rd_addr(i_rd_addr), .rd_data(i_rd_data), .rd_busy(i_rd_busy),
    .wr0_en(i_wr0_en), .wr0_addr(i_wr0_addr), .wr0_data(i_wr0_data),
    .wr1_en(i_wr1_en), .wr1_addr(i_wr1_addr), .wr1_data(i_wr1_data),
    .iss_en(i_iss_en), .iss_addr(i_iss_addr),
    .iss_busy(i_iss_busy), .busy_any(i_busy_any)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD_F), .ZERO_REG(0)) u_fp (
    .clk(clk), .rst(rst),
    .rd_addr(f_rd_addr), .rd_data(f_rd_data), .rd_busy(f_rd_busy),
    .wr0_en(f_wr0_en), .wr0_addr(f_wr0_addr), .wr0_data(f_wr0_data),
    .wr1_en(f_wr1_en), .wr1_addr(f_wr1_addr), .wr1_data(f_wr1_data),
    .iss_en(f_iss_en), .iss_addr(f_iss_addr),
    .iss_busy(f_iss_busy), .busy_any(f_busy_any)
  );

  // ---------------- driver tasks ----------------
  task automatic idle();
    i_wr0_en = 1'b0; i_wr0_addr = '0; i_wr0_data = '0;
    i_wr1_en = 1'b0; i_wr1_addr = '0; i_wr1_data = '0;
    i_iss_en = 1'b0; i_iss_addr = '0;
    f_wr0_en = 1'b0; f_wr0_addr = '0; f_wr0_data = '0;
    f_wr1_en = 1'b0; f_wr1_addr = '0; f_wr1_data = '0;
    f_iss_en = 1'b0; f_iss_addr = '0;
  endtask

  // advance one edge, drop strobes, let combinational outputs settle
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic i_wr0(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    i_wr0_en = 1'b1; i_wr0_addr = a; i_wr0_data = d;
  endtask

  task automatic i_wr1(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    i_wr1_en = 1'b1; i_wr1_addr = a; i_wr1_data = d;
  endtask

  task automatic i_iss(input logic [AW-1:0] a);
    i_iss_en = 1'b1; i_iss_addr = a;
  endtask

  task automatic i_rda(input int p, input logic [AW-1:0] a);
    i_rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] ird(input int p);
    return i_rd_data[p*XLEN +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] frd(input int p);
    return f_rd_data[p*XLEN +: XLEN];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    // initial reset, outputs must be zero
    n_vec++; if (i_busy_any !== 1'b0) begin n_bad++; $display("FAIL reset_busy_any: got %b expected 0", i_busy_any); end
    n_vec++; if (ird(0) !== 64'h0) begin n_bad++; $display("FAIL reset_rd0: got %h expected 0", ird(0)); end
    #4 rst = 1'b0;
    tick();
    // x5 = 0xAA then mark it pending
    i_wr0(5'd5, 64'hAA);
    tick();
    i_iss(5'd5);
    tick();
    i_rda(0, 5'd5); i_iss_addr = 5'd5;
    #1;
    n_vec++; if (ird(0) !== 64'hAA) begin n_bad++; $display("FAIL pre_rst_x5: got %h expected aa", ird(0)); end
    n_vec++; if (i_rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL pre_rst_busy5: got %b expected 1", i_rd_busy[0]); end
    // mid-cycle asynchronous reset
    #1 rst = 1'b1;
    #1;
    n_vec++; if (ird(0) !== 64'h0) begin n_bad++; $display("FAIL async_rst_rd: got %h expected 0", ird(0)); end
    n_vec++; if (i_busy_any !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy_any: got %b expected 0", i_busy_any); end
    n_vec++; if (i_rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL async_rst_rd_busy: got %b expected 0", i_rd_busy[0]); end
    n_vec++; if (i_iss_busy !== 1'b0) begin n_bad++; $display("FAIL async_rst_iss_busy: got %b expected 0", i_iss_busy); end
    // activity while in reset is discarded
    i_wr0(5'd6, 64'h33); i_iss(5'd6); i_rda(0, 5'd6);
    #1;
    n_vec++; if (ird(0) !== 64'h0) begin n_bad++; $display("FAIL in_rst_fwd: got %h expected 0", ird(0)); end
    tick();
    #1 rst = 1'b0;
    #1;
    n_vec++; if (ird(0) !== 64'h0) begin n_bad++; $display("FAIL rst_drop_wr: got %h expected 0", ird(0)); end
    n_vec++; if (i_busy_any !== 1'b0) begin n_bad++; $display("FAIL rst_drop_iss: got %b expected 0", i_busy_any); end
  endtask

  task automatic test_zero_reg();
    i_rda(0, 5'd0);
    i_wr0(5'd0, 64'hDEAD); i_wr1(5'd0, 64'hBEEF); i_iss(5'd0);
    #1;
    n_vec++; if (ird(0) !== 64'h0) begin n_bad++; $display("FAIL x0_same_cycle: got %h expected 0", ird(0)); end
    tick();
    i_iss_addr = 5'd0;
    #1;
    n_vec++; if (ird(0) !== 64'h0) begin n_bad++; $display("FAIL x0_read: got %h expected 0", ird(0)); end
    n_vec++; if (i_busy_any !== 1'b0) begin n_bad++; $display("FAIL x0_busy_any: got %b expected 0", i_busy_any); end
    n_vec++; if (i_iss_busy !== 1'b0) begin n_bad++; $display("FAIL x0_iss_busy: got %b expected 0", i_iss_busy); end
  endtask

  task automatic test_dual_write();
    i_rda(0, 5'd3); i_rda(1, 5'd7);
    i_wr0(5'd3, 64'h11); i_wr1(5'd7, 64'h22);
    #1;
    n_vec++; if (ird(0) !== (BYP ? 64'h11 : 64'h0)) begin n_bad++; $display("FAIL dual_wp0_same_cycle: got %h", ird(0)); end
    n_vec++; if (ird(1) !== (BYP ? 64'h22 : 64'h0)) begin n_bad++; $display("FAIL dual_wp1_same_cycle: got %h", ird(1)); end
    tick();
    n_vec++; if (ird(0) !== 64'h11) begin n_bad++; $display("FAIL dual_x3: got %h expected 11", ird(0)); end
    n_vec++; if (ird(1) !== 64'h22) begin n_bad++; $display("FAIL dual_x7: got %h expected 22", ird(1)); end
  endtask

  task automatic test_collision();
    i_rda(0, 5'd9); i_rda(1, 5'd9);
    i_wr0(5'd9, 64'h1); i_wr1(5'd9, 64'h2);
    #1;
    n_vec++; if (ird(1) !== (BYP ? 64'h1 : 64'h0)) begin n_bad++; $display("FAIL coll_same_cycle: got %h", ird(1)); end
    tick();
    n_vec++; if (ird(0) !== 64'h1) begin n_bad++; $display("FAIL coll_x9_p0: got %h expected 1", ird(0)); end
    n_vec++; if (ird(1) !== 64'h1) begin n_bad++; $display("FAIL coll_x9_p1: got %h expected 1", ird(1)); end
  endtask

  task automatic test_scoreboard();
    i_iss(5'd12);
    tick();
    i_rda(1, 5'd12); i_rda(0, 5'd3); i_iss_addr = 5'd12;
    #1;
    n_vec++; if (i_rd_busy[1] !== 1'b1) begin n_bad++; $display("FAIL sb_rd_busy12: got %b expected 1", i_rd_busy[1]); end
    n_vec++; if (i_rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL sb_rd_busy3: got %b expected 0", i_rd_busy[0]); end
    n_vec++; if (i_busy_any !== 1'b1) begin n_bad++; $display("FAIL sb_busy_any: got %b expected 1", i_busy_any); end
    n_vec++; if (i_iss_busy !== 1'b1) begin n_bad++; $display("FAIL sb_iss_busy12: got %b expected 1", i_iss_busy); end
    // iss_busy reflects state only, not this cycle's issue
    i_iss(5'd13);
    #1;
    n_vec++; if (i_iss_busy !== 1'b0) begin n_bad++; $display("FAIL sb_iss_busy13: got %b expected 0", i_iss_busy); end
    idle();
    i_wr1(5'd12, 64'h55);
    #1;
    n_vec++; if (i_rd_busy[1] !== (BYP ? 1'b0 : 1'b1)) begin n_bad++; $display("FAIL sb_wb_cycle_busy: got %b", i_rd_busy[1]); end
    n_vec++; if (ird(1) !== (BYP ? 64'h55 : 64'h0)) begin n_bad++; $display("FAIL sb_wb_cycle_data: got %h", ird(1)); end
    tick();
    n_vec++; if (i_rd_busy[1] !== 1'b0) begin n_bad++; $display("FAIL sb_cleared: got %b expected 0", i_rd_busy[1]); end
    n_vec++; if (ird(1) !== 64'h55) begin n_bad++; $display("FAIL sb_x12: got %h expected 55", ird(1)); end
    n_vec++; if (i_busy_any !== 1'b0) begin n_bad++; $display("FAIL sb_busy_any_idle: got %b expected 0", i_busy_any); end
  endtask

  task automatic test_set_clear();
    i_iss(5'd4);
    tick();
    i_rda(0, 5'd4);
    i_iss(5'd4); i_wr0(5'd4, 64'h9);
    #1;
    n_vec++; if (i_rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL sc_cycle_busy: got %b expected 1", i_rd_busy[0]); end
    tick();
    n_vec++; if (ird(0) !== 64'h9) begin n_bad++; $display("FAIL sc_x4: got %h expected 9", ird(0)); end
    n_vec++; if (i_rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL sc_busy4: got %b expected 1", i_rd_busy[0]); end
    i_wr0(5'd4, 64'hA);
    tick();
    n_vec++; if (i_rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL sc_busy4_clear: got %b expected 0", i_rd_busy[0]); end
    n_vec++; if (ird(0) !== 64'hA) begin n_bad++; $display("FAIL sc_x4_final: got %h expected a", ird(0)); end
  endtask

  task automatic test_bypass();
    i_wr0(5'd8, 64'h10);
    tick();
    i_rda(1, 5'd8);
    i_wr0(5'd8, 64'h77);
    #1;
    n_vec++; if (ird(1) !== (BYP ? 64'h77 : 64'h10)) begin n_bad++; $display("FAIL byp_x8_cycle: got %h", ird(1)); end
    tick();
    n_vec++; if (ird(1) !== 64'h77) begin n_bad++; $display("FAIL byp_x8_next: got %h expected 77", ird(1)); end
    i_wr0(5'd8, 64'h88); i_wr1(5'd8, 64'h99);
    #1;
    n_vec++; if (ird(1) !== (BYP ? 64'h88 : 64'h77)) begin n_bad++; $display("FAIL byp_prio_cycle: got %h", ird(1)); end
    tick();
    n_vec++; if (ird(1) !== 64'h88) begin n_bad++; $display("FAIL byp_prio_next: got %h expected 88", ird(1)); end
  endtask

  task automatic test_reissue();
    i_iss(5'd20);
    tick();
    i_iss(5'd20);
    tick();
    i_iss_addr = 5'd20;
    #1;
    n_vec++; if (i_iss_busy !== 1'b1) begin n_bad++; $display("FAIL reiss_busy: got %b expected 1", i_iss_busy); end
    i_wr1(5'd20, 64'h5);
    tick();
    i_iss_addr = 5'd20;
    #1;
    n_vec++; if (i_iss_busy !== 1'b0) begin n_bad++; $display("FAIL reiss_cleared: got %b expected 0", i_iss_busy); end
  endtask

  task automatic test_back_to_back();
    i_rda(0, 5'd15);
    for (int k = 1; k <= 3; k++) begin
      i_wr0(5'd15, 64'(k));
      #1;
      n_vec++; if (ird(0) !== (BYP ? 64'(k) : 64'(k - 1))) begin n_bad++; $display("FAIL b2b_cycle%0d: got %h", k, ird(0)); end
      tick();
    end
    n_vec++; if (ird(0) !== 64'h3) begin n_bad++; $display("FAIL b2b_final: got %h expected 3", ird(0)); end
  endtask

  task automatic test_fp();
    f_rd_addr = '0;
    f_wr0_en = 1'b1; f_wr0_addr = 5'd0; f_wr0_data = 64'h3FF0000000000000;
    tick();
    for (int p = 0; p < NRD_F; p++) begin
      n_vec++; if (frd(p) !== 64'h3FF0000000000000) begin n_bad++; $display("FAIL fp_f0_port%0d: got %h expected 3ff0000000000000", p, frd(p)); end
    end
    f_iss_en = 1'b1; f_iss_addr = 5'd0;
    tick();
    n_vec++; if (f_busy_any !== 1'b1) begin n_bad++; $display("FAIL fp_busy_any: got %b expected 1", f_busy_any); end
    n_vec++; if (f_rd_busy !== 3'b111) begin n_bad++; $display("FAIL fp_rd_busy: got %b expected 111", f_rd_busy); end
    f_wr1_en = 1'b1; f_wr1_addr = 5'd0; f_wr1_data = 64'h4000000000000000;
    tick();
    n_vec++; if (f_busy_any !== 1'b0) begin n_bad++; $display("FAIL fp_busy_clear: got %b expected 0", f_busy_any); end
    n_vec++; if (frd(2) !== 64'h4000000000000000) begin n_bad++; $display("FAIL fp_f0_wp1: got %h expected 4000000000000000", frd(2)); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle();
    i_rd_addr = '0;
    f_rd_addr = '0;
    #1 rst = 1'b1;
    #2;
    test_reset();
    test_zero_reg();
    test_dual_write();
    test_collision();
    test_scoreboard();
    test_set_clear();
    test_bypass();
    test_reissue();
    test_back_to_back();
    test_fp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
